result_pipe: RTL and testbench
==============================

// Module: result_pipe
// PURPOSE
//  Producer side of the operand-forwarding interface: carries each instruction's destination register,
//  result and write-enable from ID through EXE, MEM and WB. Drives rd_*/data_*/Wreg_* for the forwarding
//  unit and the WB register-file write. Owns load-use detection, branch flush and the data-memory
//  handshake stall.
// PARAMETERS
//  XLEN   32  datapath width
//  RAW    5   register address width
//  CNTW   16  width of memory-stall performance counter
// PORTS
//  Clock       in   1     single clock, all state on rising edge
//  nReset      in   1     asynchronous, active-low reset
//  valid_ID    in   1     instruction in ID is real (0 = bubble)
//  rd_ID       in   RAW   destination of ID instruction
//  Wreg_ID     in   1     ID instruction writes rd
//  isLoad_ID   in   1     ID instruction is a load
//  isStore_ID  in   1     ID instruction is a store
//  addr1_ID    in   RAW   rs1 address read in ID
//  addr2_ID    in   RAW   rs2 address read in ID
//  alu_EXE     in   XLEN  ALU result of instruction now in EXE (combinational)
//  flush       in   1     taken branch resolved in EXE; kill ID->EXE transfer
//  mem_ready   in   1     data memory completes access this cycle
//  mem_rdata   in   XLEN  load data, valid when mem_ready=1
//  mem_req     out  1     MEM stage holds a valid load/store
//  mem_addr    out  XLEN  access address (= MEM-stage ALU result)
//  stall_ID    out  1     hold PC and IF/ID register this cycle
//  rd_EXE, rd_MEM, rd_WB        out RAW   destination per stage
//  data_EXE, data_MEM, data_WB  out XLEN  forwardable result per stage
//  Wreg_EXE, Wreg_MEM, Wreg_WB  out 1     result valid for forwarding / RF write
//  stall_cnt   out  CNTW  cycles spent waiting on mem_ready, saturating
// BEHAVIOUR
//  Reset (nReset=0, async): all stage valid/Wreg/isLoad/isStore=0, rd=0, data=0, FSM=IDLE, stall_cnt=0.
//    Hence all Wreg_*=0, mem_req=0, stall_ID=0 during and right after reset; mid-access reset drops request.
//  mem_wait = mem_req & ~mem_ready.  advance = ~mem_wait (whole pipe freezes while waiting).
//  load_use = valid_ID & src match (addrN_ID!=0 & ==rd) against
//    (valid_EXE & isLoad_EXE) or (valid_MEM & isLoad_MEM & ~mem_ready).
//  stall_ID = load_use | mem_wait.
//  EXE reg, on advance: load ID fields; bubble (valid=0, Wreg=0) if load_use | flush | ~valid_ID.
//  MEM reg, on advance: load EXE fields, data_MEM_r <= alu_EXE. WB reg, on advance: load MEM fields,
//    data_WB_r <= isLoad_MEM ? mem_rdata : data_MEM_r. When advance=0 all regs hold.
//  WB never freezes its output meaning: Wreg_WB pulses one cycle per retiring instr; held instr during
//    a freeze is written again with same value (idempotent, permitted).
//  Outputs: data_EXE = alu_EXE; data_MEM = isLoad_MEM ? mem_rdata : data_MEM_r; data_WB = data_WB_r.
//  Wreg_EXE = valid & Wreg & ~isLoad & rd!=0.  Wreg_MEM = valid & Wreg & rd!=0 & (~isLoad | mem_ready).
//  Wreg_WB = valid & Wreg & rd!=0.  x0 is never reported writable at any stage.
//  mem_req = valid_MEM & (isLoad_MEM | isStore_MEM); mem_addr = data_MEM_r. mem_ready same cycle = 0 wait.
//  FSM (stats + protocol check): IDLE -> WAIT when mem_wait; WAIT stays while mem_wait, -> IDLE on
//    mem_ready. stall_cnt += 1 each mem_wait cycle, saturates at all-ones. mem_req must not drop in WAIT.
//  Simultaneous flush & load_use: bubble (same result). flush during mem_wait: ignored (ID held; branch
//    unit reasserts). flush has no effect on MEM/WB.
// STRUCTURE
//  Package pipe_pkg: typedef struct stage_t {valid, Wreg, isLoad, isStore, rd[RAW], data[XLEN]};
//    enum mem_state_t {MEM_IDLE, MEM_WAIT}; constant REG_ZERO = '0.
//  One sub-module: hazard_detect (combinational load_use from ID addrs vs EXE/MEM stage_t).
//  Stage registers and FSM live in result_pipe.
// TESTING
//  1 ALU chain: ADD x5 (alu=0x10) then ADD x6 -> next cycle rd_EXE=5,Wreg_EXE=1,data_EXE=0x10; then MEM, WB.
//  2 Load-use: LW x7 in EXE, ID reads addr1=7 -> stall_ID=1 one cycle, bubble into EXE, no stall after
//    with mem_ready=1; data_MEM=mem_rdata=0xCAFE, Wreg_MEM=1 that cycle.
//  3 Mem wait: load in MEM, mem_ready low 3 cycles -> stall_ID=1, all rd/data held, Wreg_MEM=0,
//    stall_cnt=3; ready -> data_WB=mem_rdata next cycle, Wreg_WB=1.
//  4 x0: instr with rd=0, Wreg_ID=1 -> Wreg_EXE/MEM/WB all 0; load to x0 with addr1=0 -> no stall.
//  5 Flush: flush=1 with valid ADD in ID -> EXE valid=0 next cycle; flush during mem_wait -> no bubble.
//  6 Reset mid-wait: nReset low while mem_req=1 -> mem_req,stall_ID,Wreg_* 0 immediately, cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the result pipeline: per-stage record, memory FSM states
// and the hard-wired zero register address.
package pipe_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int CNTW = 16;

  localparam logic [RAW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic            valid;
    logic            Wreg;
    logic            isLoad;
    logic            isStore;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] data;
  } stage_t;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  // A stage produces a register-file write only for a real instruction that
  // targets something other than x0.
  function automatic logic writes_reg(input stage_t s);
    return s.valid & s.Wreg & (s.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/result_pipe_hazard_detect.sv
// Load-use detection: an ID source register that matches a load whose data
// is not yet available (in EXE, or in MEM while the memory has not answered).
module hazard_detect
  import pipe_pkg::*;
(
  input  logic           valid_id,
  input  logic [RAW-1:0] addr1,
  input  logic [RAW-1:0] addr2,
  input  stage_t         exe,
  input  stage_t         mem,
  input  logic           mem_ready,
  output logic           load_use
);

  function automatic logic src_hit(input logic [RAW-1:0] addr,
                                   input stage_t s,
                                   input logic pending);
    return (addr != REG_ZERO) & s.valid & s.isLoad & pending & (addr == s.rd);
  endfunction

  logic hit1;
  logic hit2;

  // A load in MEM only blocks while its data has not arrived this cycle.
  assign hit1 = src_hit(addr1, exe, 1'b1) | src_hit(addr1, mem, ~mem_ready);
  assign hit2 = src_hit(addr2, exe, 1'b1) | src_hit(addr2, mem, ~mem_ready);

  assign load_use = valid_id & (hit1 | hit2);

  logic unused_fields;
  assign unused_fields = ^{exe.Wreg, exe.isStore, exe.data,
                           mem.Wreg, mem.isStore, mem.data};

endmodule

// File: rtl/result_pipe.sv
// EXE/MEM/WB result pipeline feeding the forwarding unit and the register
// file, with load-use stall, branch flush and data-memory wait handling.
module result_pipe
  import pipe_pkg::*;
(
  input  logic            Clock,
  input  logic            nReset,
  input  logic            valid_ID,
  input  logic [RAW-1:0]  rd_ID,
  input  logic            Wreg_ID,
  input  logic            isLoad_ID,
  input  logic            isStore_ID,
  input  logic [RAW-1:0]  addr1_ID,
  input  logic [RAW-1:0]  addr2_ID,
  input  logic [XLEN-1:0] alu_EXE,
  input  logic            flush,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic            stall_ID,
  output logic [RAW-1:0]  rd_EXE,
  output logic [RAW-1:0]  rd_MEM,
  output logic [RAW-1:0]  rd_WB,
  output logic [XLEN-1:0] data_EXE,
  output logic [XLEN-1:0] data_MEM,
  output logic [XLEN-1:0] data_WB,
  output logic            Wreg_EXE,
  output logic            Wreg_MEM,
  output logic            Wreg_WB,
  output logic [CNTW-1:0] stall_cnt,
  output mem_state_t      mem_state
);

  stage_t          exe_q, mem_q, wb_q;
  stage_t          exe_d, mem_d, wb_d;
  mem_state_t      state_q, state_d;
  logic [CNTW-1:0] cnt_q;
  logic            mem_wait;
  logic            advance;
  logic            load_use;
  logic            take_id;
  logic [XLEN-1:0] mem_result;

  hazard_detect u_hazard (
    .valid_id  (valid_ID),
    .addr1     (addr1_ID),
    .addr2     (addr2_ID),
    .exe       (exe_q),
    .mem       (mem_q),
    .mem_ready (mem_ready),
    .load_use  (load_use)
  );

  assign mem_req    = mem_q.valid & (mem_q.isLoad | mem_q.isStore);
  assign mem_wait   = mem_req & ~mem_ready;
  assign advance    = ~mem_wait;
  assign stall_ID   = load_use | mem_wait;
  // A flush seen while frozen is dropped: ID is held and the branch unit reasserts.
  assign take_id    = valid_ID & ~load_use & ~flush;
  assign mem_result = mem_q.isLoad ? mem_rdata : mem_q.data;

  always_comb begin
    exe_d         = '0;
    exe_d.valid   = take_id;
    exe_d.Wreg    = Wreg_ID & take_id;
    exe_d.isLoad  = isLoad_ID;
    exe_d.isStore = isStore_ID;
    exe_d.rd      = rd_ID;

    mem_d         = exe_q;
    mem_d.data    = alu_EXE;

    wb_d          = mem_q;
    wb_d.data     = mem_result;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (advance) begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Memory-wait FSM: tracks stall episodes and anchors the request-hold check.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (mem_wait)  state_d = MEM_WAIT;
      MEM_WAIT: if (!mem_wait) state_d = MEM_IDLE;
      default:                 state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (mem_wait && (cnt_q != {CNTW{1'b1}})) cnt_q <= cnt_q + CNTW'(1);
    end
  end

  always @(posedge Clock) begin
    if (nReset && (state_q == MEM_WAIT)) assert (mem_req);
  end

  assign mem_addr  = mem_q.data;
  assign rd_EXE    = exe_q.rd;
  assign rd_MEM    = mem_q.rd;
  assign rd_WB     = wb_q.rd;
  assign data_EXE  = alu_EXE;
  assign data_MEM  = mem_result;
  assign data_WB   = wb_q.data;
  // A load in EXE has no data yet; in MEM it is forwardable only once memory answers.
  assign Wreg_EXE  = writes_reg(exe_q) & ~exe_q.isLoad;
  assign Wreg_MEM  = writes_reg(mem_q) & (~mem_q.isLoad | mem_ready);
  assign Wreg_WB   = writes_reg(wb_q);
  assign stall_cnt = cnt_q;
  assign mem_state = state_q;

  logic unused_fields;
  assign unused_fields = ^{wb_q.isLoad, wb_q.isStore};

endmodule

// File: tb/tb_result_pipe.sv
// Randomized bench for result_pipe: a transaction-level model of the three
// stages predicts every output each cycle; retired writes go through exp_q.
module tb_result_pipe;
  import pipe_pkg::*;

  logic            Clock = 1'b0;
  logic            nReset;
  logic            valid_ID, Wreg_ID, isLoad_ID, isStore_ID, flush, mem_ready;
  logic [RAW-1:0]  rd_ID, addr1_ID, addr2_ID;
  logic [XLEN-1:0] alu_EXE, mem_rdata;
  logic            mem_req, stall_ID, Wreg_EXE, Wreg_MEM, Wreg_WB;
  logic [XLEN-1:0] mem_addr, data_EXE, data_MEM, data_WB;
  logic [RAW-1:0]  rd_EXE, rd_MEM, rd_WB;
  logic [CNTW-1:0] stall_cnt;
  mem_state_t      mem_state;

  result_pipe dut (
    .Clock(Clock), .nReset(nReset), .valid_ID(valid_ID), .rd_ID(rd_ID),
    .Wreg_ID(Wreg_ID), .isLoad_ID(isLoad_ID), .isStore_ID(isStore_ID),
    .addr1_ID(addr1_ID), .addr2_ID(addr2_ID), .alu_EXE(alu_EXE), .flush(flush),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_req(mem_req),
    .mem_addr(mem_addr), .stall_ID(stall_ID), .rd_EXE(rd_EXE), .rd_MEM(rd_MEM),
    .rd_WB(rd_WB), .data_EXE(data_EXE), .data_MEM(data_MEM), .data_WB(data_WB),
    .Wreg_EXE(Wreg_EXE), .Wreg_MEM(Wreg_MEM), .Wreg_WB(Wreg_WB),
    .stall_cnt(stall_cnt), .mem_state(mem_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit            valid;
    bit            wreg;
    bit            ld;
    bit            st;
    bit [RAW-1:0]  rd;
    bit [XLEN-1:0] data;
  } slot_t;

  slot_t                 m_exe, m_mem, m_wb;
  bit [CNTW-1:0]         m_cnt;
  bit                    m_prev_wait;
  bit                    m_new_wb;
  logic [RAW+XLEN-1:0]   exp_q[$];

  task automatic model_reset();
    m_exe = '{default: 0};
    m_mem = '{default: 0};
    m_wb  = '{default: 0};
    m_cnt = '0;
    m_prev_wait = 0;
    m_new_wb = 0;
    exp_q.delete();
  endtask

  // A source is blocked by a load whose value does not exist yet.
  function automatic bit src_hit(input bit [RAW-1:0] a);
    if (a == 0) return 0;
    if (m_exe.valid && m_exe.ld && m_exe.rd == a) return 1;
    if (m_mem.valid && m_mem.ld && !mem_ready && m_mem.rd == a) return 1;
    return 0;
  endfunction

  function automatic bit writes(input slot_t s);
    return s.valid && s.wreg && (s.rd != 0);
  endfunction

  // ---------------- driver ----------------
  task automatic clear_inputs();
    valid_ID = 0; rd_ID = '0; Wreg_ID = 0; isLoad_ID = 0; isStore_ID = 0;
    addr1_ID = '0; addr2_ID = '0; alu_EXE = '0; flush = 0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  // Called at posedge+1: drive inputs, check at negedge, advance model at next edge.
  task automatic step(input int ready_pct);
    int            kind;
    bit            m_req, m_wait, m_lu;
    bit [XLEN-1:0] mem_res;
    slot_t         n_exe, n_mem, n_wb;

    kind       = $urandom_range(0, 3);
    valid_ID   = ($urandom_range(0, 3) != 0);
    rd_ID      = RAW'($urandom_range(0, 3));
    Wreg_ID    = ($urandom_range(0, 4) != 0);
    isLoad_ID  = (kind == 0);
    isStore_ID = (kind == 1);
    addr1_ID   = RAW'($urandom_range(0, 3));
    addr2_ID   = RAW'($urandom_range(0, 3));
    alu_EXE    = $urandom;
    flush      = ($urandom_range(0, 7) == 0);
    mem_ready  = ($urandom_range(0, 99) < ready_pct);
    mem_rdata  = $urandom;
    #4;

    m_req   = m_mem.valid && (m_mem.ld || m_mem.st);
    m_wait  = m_req && !mem_ready;
    m_lu    = valid_ID && (src_hit(addr1_ID) || src_hit(addr2_ID));
    mem_res = m_mem.ld ? mem_rdata : m_mem.data;

    check_val("stall_ID", stall_ID, m_lu || m_wait);
    check_val("mem_req", mem_req, m_req);
    if (m_req) check_val("mem_addr", mem_addr, m_mem.data);
    check_val("Wreg_EXE", Wreg_EXE, writes(m_exe) && !m_exe.ld);
    check_val("Wreg_MEM", Wreg_MEM, writes(m_mem) && (!m_mem.ld || mem_ready));
    check_val("Wreg_WB", Wreg_WB, writes(m_wb));
    check_val("data_EXE", data_EXE, alu_EXE);
    if (m_exe.valid) check_val("rd_EXE", rd_EXE, m_exe.rd);
    if (m_mem.valid) begin
      check_val("rd_MEM", rd_MEM, m_mem.rd);
      check_val("data_MEM", data_MEM, mem_res);
    end
    if (m_wb.valid) begin
      check_val("rd_WB", rd_WB, m_wb.rd);
      check_val("data_WB", data_WB, m_wb.data);
    end
    check_val("stall_cnt", stall_cnt, m_cnt);
    check_val("mem_state", mem_state, m_prev_wait ? 1 : 0);

    // scoreboard: each newly retiring write must match the oldest expected one
    if (m_new_wb && writes(m_wb)) begin
      if (exp_q.size() == 0) check_val("wb_unexpected", 1, 0);
      else check_val("wb_retire", {rd_WB, data_WB}, exp_q.pop_front());
    end

    if (!m_wait) begin
      n_wb        = m_mem;
      n_wb.data   = mem_res;
      n_mem       = m_exe;
      n_mem.data  = alu_EXE;
      n_exe.valid = valid_ID && !m_lu && !flush;
      n_exe.wreg  = Wreg_ID && n_exe.valid;
      n_exe.ld    = isLoad_ID;
      n_exe.st    = isStore_ID;
      n_exe.rd    = rd_ID;
      n_exe.data  = '0;
      if (writes(n_wb)) exp_q.push_back({n_wb.rd, n_wb.data});
    end else begin
      n_wb  = m_wb;
      n_mem = m_mem;
      n_exe = m_exe;
    end

    @(posedge Clock);
    #1;
    m_exe = n_exe;
    m_mem = n_mem;
    m_wb  = n_wb;
    m_new_wb = !m_wait;
    if (m_wait && m_cnt != '1) m_cnt++;
    m_prev_wait = m_wait;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    clear_inputs();
    nReset = 0;
    model_reset();
    #2;
    check_val("rst_mem_req", mem_req, 0);
    check_val("rst_stall_ID", stall_ID, 0);
    check_val("rst_Wreg", {Wreg_EXE, Wreg_MEM, Wreg_WB}, 0);
    check_val("rst_rd", {rd_EXE, rd_MEM, rd_WB}, 0);
    check_val("rst_data_WB", data_WB, 0);
    check_val("rst_stall_cnt", stall_cnt, 0);
    check_val("rst_state", mem_state, 0);
    repeat (2) @(posedge Clock);
    #1;
    nReset = 1;

    repeat (300) step(100);
    repeat (500) step(55);

    // drive memory-ready low until a load/store sits in MEM, then reset mid-wait
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(0);
      found = m_mem.valid && (m_mem.ld || m_mem.st);
    end
    check_val("reach_wait", found, 1);
    if (found) begin
      check_val("pre_rst_mem_req", mem_req, 1);
      check_val("pre_rst_stall_ID", stall_ID, 1);
      nReset = 0;
      #1;
      check_val("mid_rst_mem_req", mem_req, 0);
      check_val("mid_rst_stall_ID", stall_ID, 0);
      check_val("mid_rst_Wreg", {Wreg_EXE, Wreg_MEM, Wreg_WB}, 0);
      check_val("mid_rst_stall_cnt", stall_cnt, 0);
      check_val("mid_rst_state", mem_state, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
